matrix_scan_capture: RTL and testbench

MATRIX_SCAN_CAPTURE -- requirements
Module: matrix_scan_capture

---
 rtl/matrix_pkg.sv | 22 ++
 rtl/scan_sync.sv | 69 ++++++
 rtl/matrix_scan_capture.sv | 165 ++++++++++++++++
 tb/tb_matrix_scan_capture.sv | 190 +++++++++++++++++++
 4 files changed

// File: rtl/matrix_pkg.sv
`default_nettype none
// ============================================================================
// Module   : matrix_pkg
// Purpose  : Shared geometry constants and capture-FSM state encoding for the
//            8x8 matrix scan capture block.
// Ports    : none (package)
// Revision : 1.0 - initial release
// ============================================================================
package matrix_pkg;

   localparam int NUM_COLS = 8;
   localparam int ROW_W    = 8;
   localparam int COL_W    = 3;

   typedef enum logic [1:0] {
      IDLE    = 2'd0,
      CAPTURE = 2'd1,
      COMMIT  = 2'd2
   } state_t;

endpackage : matrix_pkg
`default_nettype wire

// File: rtl/scan_sync.sv
`default_nettype none
// ============================================================================
// Module   : scan_sync
// Purpose  : Two-flop synchronizer for the scan column select and row pattern,
//            followed by a dwell counter that qualifies a stable column and
//            emits a single sample strobe per dwell.
// Ports    : clk, reset (async, active-low)
//            scan_in      - raw column select
//            seg_in       - raw row pattern
//            sample_valid - one-cycle strobe, column is stable long enough
//            sample_col   - synchronized column accompanying the strobe
//            sample_data  - synchronized row pattern accompanying the strobe
// Revision : 1.0 - initial release
// ============================================================================
module scan_sync
   import matrix_pkg::*;
#(
   parameter int STABLE_CYCLES = 16
) (
   input  logic             clk,
   input  logic             reset,
   input  logic [COL_W-1:0] scan_in,
   input  logic [ROW_W-1:0] seg_in,
   output logic             sample_valid,
   output logic [COL_W-1:0] sample_col,
   output logic [ROW_W-1:0] sample_data
);

   // The counter saturates at STABLE_CYCLES; the strobe fires on the edge that
   // moves it from STABLE_CYCLES-2 to STABLE_CYCLES-1, so it can fire only once
   // per dwell.
   localparam logic [15:0] c_sat  = 16'(STABLE_CYCLES);
   localparam logic [15:0] c_fire = 16'(STABLE_CYCLES - 2);

   logic [COL_W-1:0] r_scan_s1, r_scan_s2;
   logic [ROW_W-1:0] r_seg_s1,  r_seg_s2;
   logic [15:0]      r_dwell;
   logic             w_change;

   // A difference between the two stages means the synchronized value changes
   // on this edge, which restarts the dwell for the new value.
   assign w_change = (r_scan_s1 != r_scan_s2) || (r_seg_s1 != r_seg_s2);

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         r_scan_s1 <= '0;
         r_scan_s2 <= '0;
         r_seg_s1  <= '0;
         r_seg_s2  <= '0;
         r_dwell   <= '0;
      end else begin
         r_scan_s1 <= scan_in;
         r_scan_s2 <= r_scan_s1;
         r_seg_s1  <= seg_in;
         r_seg_s2  <= r_seg_s1;
         if (w_change) begin
            r_dwell <= '0;
         end else if (r_dwell != c_sat) begin
            r_dwell <= r_dwell + 16'd1;
         end
      end
   end

   assign sample_valid = !w_change && (r_dwell == c_fire);
   assign sample_col   = r_scan_s2;
   assign sample_data  = r_seg_s2;

endmodule : scan_sync
`default_nettype wire

// File: rtl/matrix_scan_capture.sv
`default_nettype none
// ============================================================================
// Module   : matrix_scan_capture
// Purpose  : Captures complete 8-column frames from a multiplexed 8x8 matrix
//            scan bus into a double-buffered frame store.
// Ports    : clk, reset (async, active-low)
//            scan_in/seg_in - scan bus column select and row pattern
//            rd_col/rd_data - combinational read of the committed frame
//            frame_valid    - pulse on frame commit
//            frame_changed  - pulse with frame_valid when content differs
//            seq_err        - pulse on out-of-order column
//            frame_cnt      - committed frame count (wrapping)
// Revision : 1.0 - initial release
// ============================================================================
module matrix_scan_capture
   import matrix_pkg::*;
#(
   parameter int STABLE_CYCLES = 16,
   parameter int ACTIVE_LOW    = 1
) (
   input  logic             clk,
   input  logic             reset,
   input  logic [COL_W-1:0] scan_in,
   input  logic [ROW_W-1:0] seg_in,
   input  logic [COL_W-1:0] rd_col,
   output logic [ROW_W-1:0] rd_data,
   output logic             frame_valid,
   output logic             frame_changed,
   output logic             seq_err,
   output logic [15:0]      frame_cnt
);

   localparam logic [COL_W-1:0] c_first_col = '0;
   localparam logic [COL_W-1:0] c_last_col  = COL_W'(NUM_COLS - 1);

   logic             w_sample_valid;
   logic [COL_W-1:0] w_sample_col;
   logic [ROW_W-1:0] w_sample_raw;
   logic [ROW_W-1:0] w_sample_data;

   state_t                         r_state, w_next_state;
   logic [COL_W-1:0]               r_expected, w_next_expected;
   logic [NUM_COLS-1:0][ROW_W-1:0] r_buf;
   logic [NUM_COLS-1:0][ROW_W-1:0] r_frame;
   logic [NUM_COLS-1:0][ROW_W-1:0] w_new_frame;
   logic                           w_store, w_clear, w_commit, w_err;
   logic                           r_frame_valid, r_frame_changed, r_seq_err;
   logic [15:0]                    r_frame_cnt;

   scan_sync #(
      .STABLE_CYCLES (STABLE_CYCLES)
   ) u_scan_sync (
      .clk          (clk),
      .reset        (reset),
      .scan_in      (scan_in),
      .seg_in       (seg_in),
      .sample_valid (w_sample_valid),
      .sample_col   (w_sample_col),
      .sample_data  (w_sample_raw)
   );

   // Frame storage is always active-high pixels.
   assign w_sample_data = (ACTIVE_LOW != 0) ? ~w_sample_raw : w_sample_raw;

   // The completed frame: columns 0..6 from the buffer plus the column-7
   // sample arriving on this edge.
   always_comb begin
      w_new_frame             = r_buf;
      w_new_frame[c_last_col] = w_sample_data;
   end

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         r_state <= IDLE;
      end else begin
         r_state <= w_next_state;
      end
   end

   always_comb begin
      w_next_state    = r_state;
      w_next_expected = r_expected;
      w_store         = 1'b0;
      w_clear         = 1'b0;
      w_commit        = 1'b0;
      w_err           = 1'b0;
      case (r_state)
         IDLE: begin
            if (w_sample_valid && (w_sample_col == c_first_col)) begin
               w_store         = 1'b1;
               w_next_expected = 3'd1;
               w_next_state    = CAPTURE;
            end
         end
         CAPTURE: begin
            if (w_sample_valid) begin
               if (w_sample_col == r_expected) begin
                  w_store         = 1'b1;
                  w_next_expected = r_expected + 3'd1;
                  if (w_sample_col == c_last_col) begin
                     w_commit     = 1'b1;
                     w_next_state = COMMIT;
                  end
               end else begin
                  w_err = 1'b1;
                  if (w_sample_col == c_first_col) begin
                     // A fresh column 0 restarts the frame in place.
                     w_store         = 1'b1;
                     w_next_expected = 3'd1;
                  end else begin
                     w_clear         = 1'b1;
                     w_next_expected = '0;
                     w_next_state    = IDLE;
                  end
               end
            end
         end
         COMMIT: begin
            w_next_expected = '0;
            w_next_state    = IDLE;
         end
         default: begin
            w_next_expected = '0;
            w_next_state    = IDLE;
         end
      endcase
   end

   // The frame store is written on the column-7 sampling edge so that the
   // COMMIT cycle already shows the new frame alongside the registered
   // frame_valid / frame_changed pulses.
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         r_expected      <= '0;
         r_buf           <= '0;
         r_frame         <= '0;
         r_frame_valid   <= 1'b0;
         r_frame_changed <= 1'b0;
         r_seq_err       <= 1'b0;
         r_frame_cnt     <= '0;
      end else begin
         r_expected      <= w_next_expected;
         r_frame_valid   <= w_commit;
         r_frame_changed <= w_commit && (w_new_frame != r_frame);
         r_seq_err       <= w_err;
         if (w_clear) begin
            r_buf <= '0;
         end else if (w_store) begin
            r_buf[w_sample_col] <= w_sample_data;
         end
         if (w_commit) begin
            r_frame     <= w_new_frame;
            r_frame_cnt <= r_frame_cnt + 16'd1;
         end
      end
   end

   assign rd_data       = r_frame[rd_col];
   assign frame_valid   = r_frame_valid;
   assign frame_changed = r_frame_changed;
   assign seq_err       = r_seq_err;
   assign frame_cnt     = r_frame_cnt;

endmodule : matrix_scan_capture
`default_nettype wire

// File: tb/tb_matrix_scan_capture.sv
`default_nettype none
// ============================================================================
// Module   : tb_matrix_scan_capture
// Purpose  : Directed self-checking bench for matrix_scan_capture.
// Ports    : none
// Revision : 1.0 - initial release
// ============================================================================
module tb_matrix_scan_capture;

   localparam logic [63:0] c_walk   = 64'h8040201008040201;
   localparam logic [63:0] c_glitch = 64'h804020100F040201;

   logic       clk = 1'b0;
   logic       reset = 1'b0;
   logic [2:0] scan_in = 3'd0;
   logic [7:0] seg_in = 8'hFF;
   logic [2:0] rd_col = 3'd0;
   logic [7:0] rd_data;
   logic       frame_valid, frame_changed, seq_err;
   logic [15:0] frame_cnt;

   int total = 0;
   int bad   = 0;
   int n_valid = 0, n_changed = 0, n_err = 0;
   logic [7:0] prev7 = 8'h00, at_valid7 = 8'h00, old_at_valid7 = 8'h00;

   matrix_scan_capture #(
      .STABLE_CYCLES (16),
      .ACTIVE_LOW    (1)
   ) dut (
      .clk           (clk),
      .reset         (reset),
      .scan_in       (scan_in),
      .seg_in        (seg_in),
      .rd_col        (rd_col),
      .rd_data       (rd_data),
      .frame_valid   (frame_valid),
      .frame_changed (frame_changed),
      .seq_err       (seq_err),
      .frame_cnt     (frame_cnt)
   );

   always #5 clk = ~clk;

   // Pulse monitor; rd_col is parked on 7 while frames are being sent, so
   // prev7 is the column-7 read in the cycle before each frame_valid.
   always @(negedge clk) begin
      if (frame_valid) begin
         n_valid++;
         if (frame_changed) n_changed++;
         at_valid7     = rd_data;
         old_at_valid7 = prev7;
      end
      if (seq_err) n_err++;
      prev7 = rd_data;
   end

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      total++;
      assert (obs === exp) else begin
         bad++;
         $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   task automatic drive(input logic [2:0] col, input logic [7:0] seg, input int cyc);
      scan_in = col;
      seg_in  = seg;
      repeat (cyc) @(negedge clk);
   endtask

   task automatic send_cols(input int first, input int last);
      for (int c = first; c <= last; c++) begin
         logic [7:0] one;
         one = 8'h01 << c;
         drive(3'(c), ~one, 20);
      end
   endtask

   task automatic check_frame(input string tag, input logic [63:0] exp);
      for (int c = 0; c < 8; c++) begin
         rd_col = 3'(c);
         #1;
         check($sformatf("%s_col%0d", tag, c), {24'd0, rd_data}, {24'd0, exp[c*8 +: 8]});
      end
      rd_col = 3'd7;
      @(negedge clk);
   endtask

   initial begin
      // Reset state
      repeat (3) @(negedge clk);
      check("rst_rd_data", {24'd0, rd_data}, 32'd0);
      check("rst_frame_cnt", {16'd0, frame_cnt}, 32'd0);
      check("rst_frame_valid", {31'd0, frame_valid}, 32'd0);
      check("rst_frame_changed", {31'd0, frame_changed}, 32'd0);
      check("rst_seq_err", {31'd0, seq_err}, 32'd0);
      reset  = 1'b1;
      rd_col = 3'd7;
      repeat (5) @(negedge clk);

      // Clean walking-zero frame
      send_cols(0, 7);
      repeat (4) @(negedge clk);
      check("clean_valid", n_valid, 1);
      check("clean_changed", n_changed, 1);
      check("clean_cnt", {16'd0, frame_cnt}, 32'd1);
      check("clean_err", n_err, 0);
      check("clean_new_at_valid", {24'd0, at_valid7}, 32'h80);
      check("clean_old_before_valid", {24'd0, old_at_valid7}, 32'h00);
      check_frame("clean", c_walk);

      // Identical frame again
      send_cols(0, 7);
      repeat (4) @(negedge clk);
      check("repeat_valid", n_valid, 2);
      check("repeat_changed", n_changed, 1);
      check("repeat_cnt", {16'd0, frame_cnt}, 32'd2);
      check("repeat_old_before_valid", {24'd0, old_at_valid7}, 32'h80);

      // Short glitch dwell on column 3, then a real column 3 pattern
      send_cols(0, 2);
      drive(3'd3, 8'h00, 10);
      drive(3'd3, 8'hF0, 20);
      send_cols(4, 7);
      repeat (4) @(negedge clk);
      check("glitch_valid", n_valid, 3);
      check("glitch_changed", n_changed, 2);
      check("glitch_cnt", {16'd0, frame_cnt}, 32'd3);
      check("glitch_err", n_err, 0);
      check_frame("glitch", c_glitch);

      // Out-of-order column 5 after 0,1,2
      send_cols(0, 2);
      drive(3'd5, 8'hDF, 20);
      repeat (4) @(negedge clk);
      check("order_err", n_err, 1);
      check("order_no_commit", n_valid, 3);
      check("order_cnt", {16'd0, frame_cnt}, 32'd3);
      check_frame("order_unchanged", c_glitch);
      send_cols(0, 7);
      repeat (4) @(negedge clk);
      check("order_recover_valid", n_valid, 4);
      check("order_recover_changed", n_changed, 3);
      check("order_recover_cnt", {16'd0, frame_cnt}, 32'd4);
      check_frame("order_recover", c_walk);

      // Reset in the middle of column 4 of the following frame
      send_cols(0, 7);
      repeat (2) @(negedge clk);
      check("prereset_cnt", {16'd0, frame_cnt}, 32'd5);
      send_cols(0, 3);
      drive(3'd4, 8'hEF, 8);
      reset = 1'b0;
      repeat (2) @(negedge clk);
      check("midrst_rd_data", {24'd0, rd_data}, 32'd0);
      check("midrst_cnt", {16'd0, frame_cnt}, 32'd0);
      check("midrst_valid", {31'd0, frame_valid}, 32'd0);
      check("midrst_seq_err", {31'd0, seq_err}, 32'd0);
      reset = 1'b1;
      drive(3'd4, 8'hEF, 12);
      send_cols(5, 7);
      repeat (4) @(negedge clk);
      check("postrst_partial_no_commit", n_valid, 5);
      check("postrst_partial_no_err", n_err, 1);
      send_cols(0, 7);
      repeat (4) @(negedge clk);
      check("postrst_valid", n_valid, 6);
      check("postrst_changed", n_changed, 4);
      check("postrst_cnt", {16'd0, frame_cnt}, 32'd1);
      check_frame("postrst", c_walk);

      // Counter wrap via back-door preload
      force dut.r_frame_cnt = 16'hFFFF;
      @(negedge clk);
      release dut.r_frame_cnt;
      @(negedge clk);
      check("wrap_preload", {16'd0, frame_cnt}, 32'h0000FFFF);
      send_cols(0, 7);
      repeat (4) @(negedge clk);
      check("wrap_valid", n_valid, 7);
      check("wrap_cnt", {16'd0, frame_cnt}, 32'd0);
      check("wrap_changed", n_changed, 4);

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule : tb_matrix_scan_capture
`default_nettype wire
